// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive-side frame buffer that sits directly behind uartreceiver. Each rising
//   edge of rx_valid captures one frame {rx_error, rx_data} into a circular FIFO.
//   The host drains the FIFO through a registered read port and watches the level,
//   almost-full and sticky overrun status.
//
// Ports
//   clk          system clock (UART rx_clk domain)
//   reset        asynchronous, active-low reset
//   rx_valid     frame-complete level from uartreceiver
//   rx_error     framing/stop error for the current frame
//   rx_data      received byte
//   rd_en        host read request, one entry per high cycle
//   clr_overrun  clears the sticky overrun flag
//   rd_data      popped byte, registered
//   rd_err       error flag stored with the popped byte
//   rd_valid     one-cycle pulse when rd_data/rd_err were updated
//   empty        count == 0
//   full         count == DEPTH
//   almost_full  count >= AFULL_LVL
//   count        entries held, 0..DEPTH
//   overrun      sticky: a frame was dropped because the FIFO was full

module uart_rx_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int AFULL_LVL = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic              rx_error,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rd_en,
  input  logic              clr_overrun,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overrun
);

  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   AFULL_C   = (ADDR_W+1)'(AFULL_LVL);
  localparam logic [ADDR_W:0]   CNT_ONE_C = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ZERO_C = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W-1:0] PTR_ONE_C = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Each entry holds {error, data}
  logic [DATA_W:0]   mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic              rx_valid_q_r;

  logic              wr_req_s;
  logic              rd_ok_s;
  logic              wr_ok_s;
  logic              drop_s;
  logic [ADDR_W:0]   count_next_s;

  // Strobe generation and accept decisions for this cycle
  always_comb begin
    wr_req_s = rx_valid & ~rx_valid_q_r;
    rd_ok_s  = rd_en & ~empty;
    // A read in the same cycle frees the slot a full FIFO needs
    wr_ok_s  = wr_req_s & (~full | rd_ok_s);
    drop_s   = wr_req_s & full & ~rd_ok_s;
  end

  // Next occupancy; flags are decoded from it so they register alongside count
  always_comb begin
    count_next_s = count;
    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_next_s = count + CNT_ONE_C;
      2'b01:   count_next_s = count - CNT_ONE_C;
      default: count_next_s = count;
    endcase
  end

  // rx_valid edge register; resets high so a level held through reset is not a new frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_valid_q_r <= 1'b1;
    end else begin
      rx_valid_q_r <= rx_valid;
    end
  end

  // Frame storage; contents are only meaningful between the pointers, so no reset
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= {rx_error, rx_data};
    end
  end

  // Pointers, occupancy and level flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r    <= {ADDR_W{1'b0}};
      rd_ptr_r    <= {ADDR_W{1'b0}};
      count       <= CNT_ZERO_C;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      count       <= count_next_s;
      empty       <= (count_next_s == CNT_ZERO_C);
      full        <= (count_next_s == DEPTH_C);
      almost_full <= (count_next_s >= AFULL_C);
    end
  end

  // Registered read port; rd_data/rd_err hold between reads
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data  <= {DATA_W{1'b0}};
      rd_err   <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_ok_s;
      if (rd_ok_s) begin
        rd_data <= mem_r[rd_ptr_r][DATA_W-1:0];
        rd_err  <= mem_r[rd_ptr_r][DATA_W];
      end
    end
  end

  // Sticky overrun; a drop in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun <= 1'b0;
    end else if (drop_s) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
//   Directed self-checking bench for uart_rx_fifo (DATA_W=8, DEPTH=16, AFULL_LVL=12).
//   Expected read data comes from a reference queue filled by the bench itself.

module tb_uart_rx_fifo;

  logic       clk;
  logic       reset;
  logic       rx_valid;
  logic       rx_error;
  logic [7:0] rx_data;
  logic       rd_en;
  logic       clr_overrun;
  logic [7:0] rd_data;
  logic       rd_err;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic [4:0] count;
  logic       overrun;

  int checks_cnt;
  int errors_cnt;
  logic [8:0] exp_q [$];

  uart_rx_fifo #(
    .DATA_W(8), .DEPTH(16), .ADDR_W(4), .AFULL_LVL(12)
  ) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_error(rx_error),
    .rx_data(rx_data), .rd_en(rd_en), .clr_overrun(clr_overrun),
    .rd_data(rd_data), .rd_err(rd_err), .rd_valid(rd_valid), .empty(empty),
    .full(full), .almost_full(almost_full), .count(count), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame: rx_valid high for 'hold' cycles then low for one
  task automatic send_frame(input logic [7:0] d, input logic e, input int hold);
    rx_data  = d;
    rx_error = e;
    rx_valid = 1'b1;
    if (exp_q.size() < 16) exp_q.push_back({e, d});
    repeat (hold) step();
    rx_valid = 1'b0;
    step();
    check("count_after_write", 32'(count), 32'(exp_q.size()));
  endtask

  task automatic read_one();
    logic [8:0] e;
    e = exp_q.pop_front();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("rd_valid", 32'(rd_valid), 32'd1);
    check("rd_data", 32'(rd_data), 32'(e[7:0]));
    check("rd_err", 32'(rd_err), 32'(e[8]));
    check("count_after_read", 32'(count), 32'(exp_q.size()));
  endtask

  initial begin
    checks_cnt  = 0;
    errors_cnt  = 0;
    reset       = 1'b0;
    rx_valid    = 1'b1;
    rx_error    = 1'b0;
    rx_data     = 8'h00;
    rd_en       = 1'b0;
    clr_overrun = 1'b0;

    // 1: reset with rx_valid held high
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    step();
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_afull", 32'(almost_full), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    repeat (3) step();
    check("held_valid_no_write", 32'(count), 32'd0);
    rx_valid = 1'b0;
    step();
    // read while empty is ignored
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("empty_rd_valid", 32'(rd_valid), 32'd0);
    check("empty_rd_count", 32'(count), 32'd0);
    check("empty_rd_data", 32'(rd_data), 32'd0);

    // 2: three frames, each held three cycles
    send_frame(8'h41, 1'b0, 3);
    send_frame(8'h42, 1'b0, 3);
    send_frame(8'h43, 1'b0, 3);
    check("three_count", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) read_one();
    check("three_empty", 32'(empty), 32'd1);
    step();
    check("rd_valid_pulse", 32'(rd_valid), 32'd0);
    check("rd_data_hold", 32'(rd_data), 32'h43);

    // 3: seventeen frames into sixteen entries
    for (int i = 1; i <= 17; i++) begin
      send_frame(8'(i), 1'b0, 1);
      check("afull_level", 32'(almost_full), 32'((i >= 12) ? 1 : 0));
      check("full_level", 32'(full), 32'((i >= 16) ? 1 : 0));
      check("overrun_level", 32'(overrun), 32'((i >= 17) ? 1 : 0));
    end
    // a dropped frame coincident with clr_overrun keeps overrun set
    rx_data = 8'hEE; rx_valid = 1'b1; clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0; rx_valid = 1'b0;
    check("set_beats_clear", 32'(overrun), 32'd1);
    step();
    check("drop_count", 32'(count), 32'd16);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    check("clear_overrun", 32'(overrun), 32'd0);
    for (int i = 0; i < 16; i++) read_one();
    check("drain_empty", 32'(empty), 32'd1);

    // 4: full FIFO, write edge and read in the same cycle
    for (int i = 0; i < 16; i++) send_frame(8'h80 + 8'(i), 1'b0, 1);
    check("refill_full", 32'(full), 32'd1);
    rx_data = 8'h99; rx_error = 1'b0; rx_valid = 1'b1; rd_en = 1'b1;
    step();
    rd_en = 1'b0; rx_valid = 1'b0;
    check("simul_rd_valid", 32'(rd_valid), 32'd1);
    check("simul_rd_data", 32'(rd_data), 32'h80);
    check("simul_count", 32'(count), 32'd16);
    check("simul_overrun", 32'(overrun), 32'd0);
    void'(exp_q.pop_front());
    exp_q.push_back({1'b0, 8'h99});
    step();
    for (int i = 0; i < 16; i++) read_one();

    // 5: error frame
    send_frame(8'h55, 1'b1, 2);
    read_one();

    // reset asserted mid-operation clears the FIFO immediately
    send_frame(8'h12, 1'b0, 1);
    send_frame(8'h34, 1'b0, 1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_empty", 32'(empty), 32'd1);
    exp_q.delete();
    step();
    reset = 1'b1;
    step();

    // 6: random interleave of 40 frames with reads
    begin
      int sent;
      sent = 0;
      while (sent < 40 || exp_q.size() > 0) begin
        if (sent < 40 && exp_q.size() < 16 &&
            (exp_q.size() == 0 || $urandom_range(0, 1) == 1)) begin
          send_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(1, 3)));
          sent++;
        end else begin
          read_one();
        end
      end
    end
    check("random_empty", 32'(empty), 32'd1);
    check("random_overrun", 32'(overrun), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
